// File: rtl/load_run_sequencer_pkg.sv
// Shared definitions for the load/run sequencer.
// Contents:
//   FRAME_W - host frame length in bits ({data[7:0], addr[3:0]})
//   ADDR_W  - memory write address width
//   state_e - sequencer FSM state encoding
package load_run_sequencer_pkg;

  localparam int FRAME_W = 12;
  localparam int ADDR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IRECV = 3'd1,
    ST_DRECV = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/load_run_sequencer_frame_deser.sv
// Serial frame deserialiser: shifts one bit per enabled cycle, MSB first, and
// raises a one-cycle frame-complete pulse after the last bit of a frame.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr_i        - synchronous discard of any partial frame
//   shift_i      - sample bit_i this cycle
//   bit_i        - serial data bit
//   sr_o         - shift register contents (full frame while frame_vld_o is high)
//   cnt_o        - bits received in the current frame
//   frame_vld_o  - high for the cycle following the final bit of a frame
module load_run_sequencer_frame_deser #(
  parameter int FRAME_W = load_run_sequencer_pkg::FRAME_W,
  parameter int CNT_W   = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  output logic [FRAME_W-1:0] sr_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               frame_vld_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    vld_d = 1'b0;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = {sr_q[FRAME_W-2:0], bit_i};
      // Counter wraps on the last bit so a following frame can start at once.
      if (cnt_q == LAST_BIT) begin
        cnt_d = '0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign sr_o        = sr_q;
  assign cnt_o       = cnt_q;
  assign frame_vld_o = vld_q;

endmodule

// File: rtl/load_run_sequencer.sv
// Host-link front end for the tiny processor: turns serial host frames into
// instruction/data memory write strobes and sequences the core through
// load -> run -> done with a watchdog on runaway programs.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   csi_n, csd_n        - instruction / data frame selects (active low)
//   mosi                - serial data, MSB first
//   run_req             - host run request (level)
//   core_pc_en          - core still advancing; low = program terminated
//   imem_wen, dmem_wen  - single-cycle memory write strobes
//   mem_addr, mem_wdata - write address / data, valid with either strobe
//   core_run            - core execute enable
//   core_pc_rst         - hold core PC at 0
//   done                - sequencer idle, result readable
//   frame_err           - sticky: partial frame or both selects low
//   wdog_trip           - sticky: last run aborted by watchdog
module load_run_sequencer #(
  parameter int FRAME_W = load_run_sequencer_pkg::FRAME_W,
  parameter int ADDR_W  = load_run_sequencer_pkg::ADDR_W,
  parameter int WDOG_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csi_n,
  input  logic                      csd_n,
  input  logic                      mosi,
  input  logic                      run_req,
  input  logic                      core_pc_en,
  output logic                      imem_wen,
  output logic                      dmem_wen,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [FRAME_W-ADDR_W-1:0] mem_wdata,
  output logic                      core_run,
  output logic                      core_pc_rst,
  output logic                      done,
  output logic                      frame_err,
  output logic                      wdog_trip
);

  import load_run_sequencer_pkg::*;

  localparam int CNT_W = $clog2(FRAME_W);
  // Last counted run cycle: the run lasts 2**WDOG_W-1 cycles before abort.
  localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

  state_e              state_q;
  logic                core_run_q, core_pc_rst_q, done_q;
  logic                frame_err_q, wdog_trip_q;
  logic [WDOG_W-1:0]   wdog_q;

  logic                shift, clr, frame_abort;
  logic                own_sel_n, other_sel_n;
  logic [FRAME_W-1:0]  sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic                frame_vld;

  assign own_sel_n   = (state_q == ST_DRECV) ? csd_n : csi_n;
  assign other_sel_n = (state_q == ST_DRECV) ? csi_n : csd_n;

  // The edge that leaves IDLE on a select already samples the first bit, so
  // a frame is exactly FRAME_W cycles of select low.
  always_comb begin
    shift       = 1'b0;
    clr         = 1'b0;
    frame_abort = 1'b0;
    case (state_q)
      ST_IDLE: shift = !run_req && (csi_n ^ csd_n);
      ST_IRECV, ST_DRECV: begin
        if (!other_sel_n) begin
          frame_abort = 1'b1;
          clr         = 1'b1;
        end else if (own_sel_n) begin
          frame_abort = (bit_cnt != '0);
          clr         = 1'b1;
        end else begin
          shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  load_run_sequencer_frame_deser #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_deser (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .shift_i     (shift),
    .bit_i       (mosi),
    .sr_o        (sr),
    .cnt_o       (bit_cnt),
    .frame_vld_o (frame_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      core_run_q    <= 1'b0;
      core_pc_rst_q <= 1'b1;
      done_q        <= 1'b1;
      frame_err_q   <= 1'b0;
      wdog_trip_q   <= 1'b0;
      wdog_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_req) begin
            state_q       <= ST_RUN;
            core_run_q    <= 1'b1;
            core_pc_rst_q <= 1'b0;
            done_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            wdog_trip_q   <= 1'b0;
            wdog_q        <= '0;
          end else if (!csi_n && !csd_n) begin
            frame_err_q <= 1'b1;
          end else if (!csi_n) begin
            state_q <= ST_IRECV;
          end else if (!csd_n) begin
            state_q <= ST_DRECV;
          end
        end
        ST_IRECV, ST_DRECV: begin
          if (frame_abort) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (own_sel_n) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!core_pc_en || !run_req) begin
            state_q    <= ST_DONE;
            core_run_q <= 1'b0;
          end else if (wdog_q == WDOG_LAST) begin
            wdog_q      <= '1;
            wdog_trip_q <= 1'b1;
            state_q     <= ST_DONE;
            core_run_q  <= 1'b0;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        ST_DONE: begin
          state_q       <= ST_IDLE;
          done_q        <= 1'b1;
          core_pc_rst_q <= 1'b1;
        end
        default: begin
          state_q       <= ST_IDLE;
          core_run_q    <= 1'b0;
          done_q        <= 1'b1;
          core_pc_rst_q <= 1'b1;
        end
      endcase
    end
  end

  // A completed frame is only ever flagged while in its receive state.
  assign imem_wen    = frame_vld && (state_q == ST_IRECV);
  assign dmem_wen    = frame_vld && (state_q == ST_DRECV);
  assign mem_addr    = sr[ADDR_W-1:0];
  assign mem_wdata   = sr[FRAME_W-1:ADDR_W];
  assign core_run    = core_run_q;
  assign core_pc_rst = core_pc_rst_q;
  assign done        = done_q;
  assign frame_err   = frame_err_q;
  assign wdog_trip   = wdog_trip_q;

endmodule

// File: tb/tb_load_run_sequencer.sv
// Directed bench for load_run_sequencer: frame loading, frame errors, run
// sequencing, watchdog abort (second instance with WDOG_W=4) and async reset.
module tb_load_run_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, csi_n, csd_n, mosi, run_req, run_req4, core_pc_en;
  logic       imem_wen, dmem_wen, core_run, core_pc_rst, done, frame_err, wdog_trip;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       imem_wen4, dmem_wen4, core_run4, core_pc_rst4, done4, frame_err4, wdog_trip4;
  logic [3:0] mem_addr4;
  logic [7:0] mem_wdata4;

  int n_cmp = 0;
  int n_err = 0;
  int hi;
  logic [11:0] f1;
  logic [23:0] stream;

  always #5 clk = ~clk;

  load_run_sequencer dut (
    .clk(clk), .rst_n(rst_n), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
    .run_req(run_req), .core_pc_en(core_pc_en),
    .imem_wen(imem_wen), .dmem_wen(dmem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .core_pc_rst(core_pc_rst), .done(done),
    .frame_err(frame_err), .wdog_trip(wdog_trip)
  );

  load_run_sequencer #(.WDOG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .csi_n(csi_n), .csd_n(csd_n), .mosi(mosi),
    .run_req(run_req4), .core_pc_en(core_pc_en),
    .imem_wen(imem_wen4), .dmem_wen(dmem_wen4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .core_run(core_run4), .core_pc_rst(core_pc_rst4), .done(done4),
    .frame_err(frame_err4), .wdog_trip(wdog_trip4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; csi_n = 1'b1; csd_n = 1'b1; mosi = 1'b0;
    run_req = 1'b0; run_req4 = 1'b0; core_pc_en = 1'b1;
    tick(); tick();
    chk("rst_done", done, 1);
    chk("rst_pc_rst", core_pc_rst, 1);
    chk("rst_core_run", core_run, 0);
    chk("rst_imem_wen", imem_wen, 0);
    chk("rst_dmem_wen", dmem_wen, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_wdog_trip", wdog_trip, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Instruction frame 0xA5 @ 3
    f1 = 12'hA53;
    csi_n = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      mosi = f1[i];
      tick();
      chk("i_strobe_timing", imem_wen, (i == 0));
    end
    chk("i_addr", mem_addr, 4'h3);
    chk("i_wdata", mem_wdata, 8'hA5);
    chk("i_no_dmem", dmem_wen, 0);
    csi_n = 1'b1;
    tick();
    chk("i_strobe_width", imem_wen, 0);
    chk("i_no_err", frame_err, 0);
    chk("i_done_idle", done, 1);

    // Two back-to-back data frames: 0x11 @ 0 then 0x22 @ F
    stream = {12'h110, 12'h22F};
    csd_n = 1'b0;
    for (int k = 0; k < 24; k++) begin
      mosi = stream[23-k];
      tick();
      chk("d_strobe_timing", dmem_wen, (k == 11 || k == 23));
      chk("d_no_imem", imem_wen, 0);
      if (k == 11) begin
        chk("d1_addr", mem_addr, 4'h0);
        chk("d1_wdata", mem_wdata, 8'h11);
      end
      if (k == 23) begin
        chk("d2_addr", mem_addr, 4'hF);
        chk("d2_wdata", mem_wdata, 8'h22);
      end
    end
    csd_n = 1'b1;
    tick();
    chk("d_strobe_end", dmem_wen, 0);
    chk("d_no_err", frame_err, 0);

    // Partial instruction frame: 7 bits then deselect
    csi_n = 1'b0; mosi = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("p_no_strobe", imem_wen, 0);
    end
    csi_n = 1'b1;
    tick();
    chk("p_frame_err", frame_err, 1);
    chk("p_no_strobe_end", imem_wen, 0);
    chk("p_idle_done", done, 1);
    tick();
    chk("p_err_sticky", frame_err, 1);

    // Run terminated by core_pc_en after 20 cycles
    run_req = 1'b1;
    tick();
    chk("r_core_run", core_run, 1);
    chk("r_err_cleared", frame_err, 0);
    chk("r_pc_rst_off", core_pc_rst, 0);
    chk("r_done_off", done, 0);
    hi = 1;
    while (core_run === 1'b1 && hi < 60) begin
      if (hi == 20) core_pc_en = 1'b0;
      tick();
      if (core_run === 1'b1) hi++;
    end
    chk("r_run_cycles", hi, 20);
    chk("r_done_state_done", done, 0);
    chk("r_done_state_pc_rst", core_pc_rst, 0);
    run_req = 1'b0; core_pc_en = 1'b1;
    tick();
    chk("r_idle_done", done, 1);
    chk("r_idle_pc_rst", core_pc_rst, 1);
    chk("r_no_wdog", wdog_trip, 0);
    chk("r_core_run_off", core_run, 0);

    // Watchdog abort on the WDOG_W=4 instance
    run_req4 = 1'b1;
    tick();
    chk("w_core_run", core_run4, 1);
    hi = 1;
    while (core_run4 === 1'b1 && hi < 60) begin
      tick();
      if (core_run4 === 1'b1) hi++;
    end
    chk("w_run_cycles", hi, 15);
    chk("w_trip", wdog_trip4, 1);
    run_req4 = 1'b0;
    tick();
    chk("w_idle_done", done4, 1);
    chk("w_idle_pc_rst", core_pc_rst4, 1);
    chk("w_trip_sticky", wdog_trip4, 1);

    // Reset mid-frame
    csi_n = 1'b0; mosi = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf_done", done, 1);
    chk("rf_pc_rst", core_pc_rst, 1);
    chk("rf_addr", mem_addr, 0);
    chk("rf_wdata", mem_wdata, 0);
    csi_n = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rf_no_strobe", imem_wen, 0);
    end
    chk("rf_no_err", frame_err, 0);

    // Reset mid-run
    run_req = 1'b1;
    repeat (4) tick();
    chk("rr_running", core_run, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_core_run", core_run, 0);
    chk("rr_done", done, 1);
    chk("rr_pc_rst", core_pc_rst, 1);
    run_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rr_stay_idle", core_run, 0);
    chk("rr_no_strobe", imem_wen | dmem_wen, 0);

    // Both selects low in IDLE
    csi_n = 1'b0; csd_n = 1'b0;
    tick();
    chk("b_frame_err", frame_err, 1);
    chk("b_no_strobe", imem_wen | dmem_wen, 0);
    chk("b_idle", done, 1);
    csi_n = 1'b1; csd_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
